// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute stage: control encodings from ALU
// control, and the occupancy states of the OUT/SKID result buffer.
package alu_exec_pkg;

    localparam int CTRL_ADD_WIDTH   = 2;
    localparam int CTRL_LOGIC_WIDTH = 3;

    // Adder uop controls (0 means "not an adder op")
    localparam logic [CTRL_ADD_WIDTH-1:0] CTRL_ADD  = 2'd1;
    localparam logic [CTRL_ADD_WIDTH-1:0] CTRL_SUB  = 2'd2;
    localparam logic [CTRL_ADD_WIDTH-1:0] CTRL_ADDI = 2'd3;

    // Logic uop controls (0 means "not a logic op")
    localparam logic [CTRL_LOGIC_WIDTH-1:0] CTRL_OR   = 3'd1;
    localparam logic [CTRL_LOGIC_WIDTH-1:0] CTRL_XOR  = 3'd2;
    localparam logic [CTRL_LOGIC_WIDTH-1:0] CTRL_AND  = 3'd3;
    localparam logic [CTRL_LOGIC_WIDTH-1:0] CTRL_ORI  = 3'd4;
    localparam logic [CTRL_LOGIC_WIDTH-1:0] CTRL_XORI = 3'd5;
    localparam logic [CTRL_LOGIC_WIDTH-1:0] CTRL_ANDI = 3'd6;

    // Buffer occupancy: nothing held, OUT full, OUT and SKID both full
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/alu_exec_datapath.sv
// Combinational execute datapath: operand-B select, adder, bitwise logic,
// and the illegal/write-enable qualification of a single uop.
module alu_exec_datapath
    import alu_exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic [CTRL_ADD_WIDTH-1:0]   ctrl_adder,
    input  logic                        uop_is_add,
    input  logic [CTRL_LOGIC_WIDTH-1:0] ctrl_logic,
    input  logic                        uop_is_logic,
    input  logic [XLEN-1:0]             op_a,
    input  logic [XLEN-1:0]             op_b,
    input  logic [XLEN-1:0]             imm,
    input  logic [RD_W-1:0]             rd,
    output logic [XLEN-1:0]             result,
    output logic                        we,
    output logic                        illegal
);

    logic                   use_imm;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    // Select operand B, compute the result; illegal uops yield zero and no write
    always_comb begin
        use_imm = (uop_is_add && (ctrl_adder == CTRL_ADDI)) ||
                  (uop_is_logic && ((ctrl_logic == CTRL_ORI) ||
                                    (ctrl_logic == CTRL_XORI) ||
                                    (ctrl_logic == CTRL_ANDI)));
        a_s     = op_a;
        b_s     = use_imm ? imm : op_b;
        illegal = ~(uop_is_add ^ uop_is_logic);
        result  = '0;
        if (!illegal) begin
            if (uop_is_add) begin
                case (ctrl_adder)
                    CTRL_ADD, CTRL_ADDI: result = a_s + b_s;
                    CTRL_SUB:            result = a_s - b_s;
                    default:             result = '0;
                endcase
            end else begin
                case (ctrl_logic)
                    CTRL_OR,  CTRL_ORI:  result = a_s | b_s;
                    CTRL_XOR, CTRL_XORI: result = a_s ^ b_s;
                    CTRL_AND, CTRL_ANDI: result = a_s & b_s;
                    default:             result = '0;
                endcase
            end
        end
        we = !illegal && (rd != '0);
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes each uop's result once at accept, then holds it
// in a two-entry OUT/SKID buffer so in_ready is a pure register output.
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_ADD_WIDTH-1:0]   ctrl_adder,
    input  logic                        uop_is_add,
    input  logic [CTRL_LOGIC_WIDTH-1:0] ctrl_logic,
    input  logic                        uop_is_logic,
    input  logic [XLEN-1:0]             op_a,
    input  logic [XLEN-1:0]             op_b,
    input  logic [XLEN-1:0]             imm,
    input  logic [RD_W-1:0]             rd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_result,
    output logic [RD_W-1:0]             out_rd,
    output logic                        out_we,
    output logic                        out_illegal
);

    pipe_state_t     state;
    logic            accept;
    logic            skid_load;

    logic [XLEN-1:0] calc_result;
    logic            calc_we;
    logic            calc_illegal;

    logic [XLEN-1:0] skid_result;
    logic [RD_W-1:0] skid_rd;
    logic            skid_we;
    logic            skid_illegal;

    alu_exec_datapath #(
        .XLEN (XLEN),
        .RD_W (RD_W)
    ) u_datapath (
        .ctrl_adder   (ctrl_adder),
        .uop_is_add   (uop_is_add),
        .ctrl_logic   (ctrl_logic),
        .uop_is_logic (uop_is_logic),
        .op_a         (op_a),
        .op_b         (op_b),
        .imm          (imm),
        .rd           (rd),
        .result       (calc_result),
        .we           (calc_we),
        .illegal      (calc_illegal)
    );

    assign accept    = in_valid && in_ready;
    assign skid_load = !flush && (state == ST_ONE) && accept && !out_ready;

    // Occupancy FSM with registered handshake outputs and the OUT entry;
    // flush overrides any simultaneous accept or output transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_EMPTY;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            out_result  <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state       <= ST_ONE;
                        out_valid   <= 1'b1;
                        out_result  <= calc_result;
                        out_rd      <= rd;
                        out_we      <= calc_we;
                        out_illegal <= calc_illegal;
                    end
                end
                ST_ONE: begin
                    if (accept && !out_ready) begin
                        state    <= ST_TWO;
                        in_ready <= 1'b0;
                    end else if (accept) begin
                        out_result  <= calc_result;
                        out_rd      <= rd;
                        out_we      <= calc_we;
                        out_illegal <= calc_illegal;
                    end else if (out_ready) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        state       <= ST_ONE;
                        in_ready    <= 1'b1;
                        out_result  <= skid_result;
                        out_rd      <= skid_rd;
                        out_we      <= skid_we;
                        out_illegal <= skid_illegal;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // SKID entry captures the computed result of a uop arriving while OUT is stalled
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_result  <= calc_result;
            skid_rd      <= rd;
            skid_we      <= calc_we;
            skid_illegal <= calc_illegal;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus randomized
// traffic, with a reference-model scoreboard decoupled from stimulus.
module tb_alu_exec_stage;
    import alu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ctrl_adder;
    logic        uop_is_add;
    logic [2:0]  ctrl_logic;
    logic        uop_is_logic;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ctrl_adder   (ctrl_adder),
        .uop_is_add   (uop_is_add),
        .ctrl_logic   (ctrl_logic),
        .uop_is_logic (uop_is_logic),
        .op_a         (op_a),
        .op_b         (op_b),
        .imm          (imm),
        .rd           (rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .out_illegal  (out_illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: what an instruction means, independent of how it is built
    function automatic exp_t model(input logic add, input logic lg, input logic [1:0] ca,
                                   input logic [2:0] cl, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] im,
                                   input logic [4:0] r);
        exp_t e;
        e.rd = r;
        if (add == lg) begin
            e.result = 32'd0;
            e.we     = 1'b0;
            e.ill    = 1'b1;
            return e;
        end
        e.ill = 1'b0;
        e.we  = (r != 5'd0);
        e.result = 32'd0;
        if (add) begin
            if (ca == CTRL_ADD)       e.result = a + b;
            else if (ca == CTRL_SUB)  e.result = a - b;
            else if (ca == CTRL_ADDI) e.result = a + im;
        end else begin
            if (cl == CTRL_OR)        e.result = a | b;
            else if (cl == CTRL_XOR)  e.result = a ^ b;
            else if (cl == CTRL_AND)  e.result = a & b;
            else if (cl == CTRL_ORI)  e.result = a | im;
            else if (cl == CTRL_XORI) e.result = a ^ im;
            else if (cl == CTRL_ANDI) e.result = a & im;
        end
        return e;
    endfunction

    // Stimulus side of the scoreboard: record every accepted uop, forget all on flush/reset
    always @(negedge clk) begin
        if (!reset_n || flush) sb.delete();
        else if (in_valid && in_ready)
            sb.push_back(model(uop_is_add, uop_is_logic, ctrl_adder, ctrl_logic,
                               op_a, op_b, imm, rd));
    end

    // Monitor: every output transfer must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got result %0h with no expected entry", out_result);
            end else begin
                e = sb.pop_front();
                check("out_stream", {25'd0, out_result, out_rd, out_we, out_illegal}, {25'd0, e});
            end
        end
    end

    // Offer one uop and hold it until accepted; returns 1 time unit after the accepting edge
    task automatic send(input logic add, input logic lg, input logic [1:0] ca,
                        input logic [2:0] cl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [4:0] r);
        logic got;
        got          = 1'b0;
        uop_is_add   = add;
        uop_is_logic = lg;
        ctrl_adder   = ca;
        ctrl_logic   = cl;
        op_a         = a;
        op_b         = b;
        imm          = im;
        rd           = r;
        in_valid     = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ctrl_adder = '0; ctrl_logic = '0; uop_is_add = 1'b0; uop_is_logic = 1'b0;
        op_a = '0; op_b = '0; imm = '0; rd = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_we", out_we, 0);
        check("rst_out_illegal", out_illegal, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic arithmetic with writeback always ready
        out_ready = 1'b1;
        send(1, 0, CTRL_ADD, 3'd0, 32'd5, 32'd7, 32'd0, 5'd3);
        @(negedge clk);
        check("add_latency_valid", out_valid, 1);
        check("add_result", out_result, 12);
        check("add_we", out_we, 1);
        @(posedge clk); #1;
        send(1, 0, CTRL_SUB, 3'd0, 32'd3, 32'd5, 32'd0, 5'd4);
        @(negedge clk);
        check("sub_result", out_result, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        send(1, 0, CTRL_ADDI, 3'd0, 32'h7FFF_FFFF, 32'hDEAD_0000, 32'd1, 5'd5);
        @(negedge clk);
        check("addi_wrap", out_result, 32'h8000_0000);
        @(posedge clk); #1;

        // Fill OUT and SKID with writeback stalled
        out_ready = 1'b0;
        send(0, 1, 2'd0, CTRL_XORI, 32'h0000_F0F0, 32'h1234_5678, 32'h0000_00FF, 5'd6);
        send(0, 1, 2'd0, CTRL_OR, 32'd1, 32'd2, 32'd0, 5'd7);
        @(negedge clk);
        check("skid_full_in_ready", in_ready, 0);
        check("skid_full_valid", out_valid, 1);
        check("skid_full_result", out_result, 32'h0000_F00F);
        @(posedge clk); #1;
        uop_is_add = 1'b1; uop_is_logic = 1'b0; ctrl_adder = CTRL_ADD; ctrl_logic = 3'd0;
        op_a = 32'd10; op_b = 32'd20; imm = 32'd0; rd = 5'd8; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("third_stalls", in_ready, 0);
            check("hold_result", out_result, 32'h0000_F00F);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1, 0, CTRL_ADD, 3'd0, 32'd10, 32'd20, 32'd0, 5'd8);
        @(negedge clk);
        @(posedge clk); #1;

        // rd=0 suppresses write; malformed flags flow through as illegal without stalling
        send(1, 0, CTRL_ADD, 3'd0, 32'd9, 32'd9, 32'd0, 5'd0);
        @(negedge clk);
        check("rd0_we", out_we, 0);
        @(posedge clk); #1;
        send(1, 1, CTRL_ADD, CTRL_OR, 32'd9, 32'd9, 32'd0, 5'd9);
        @(negedge clk);
        check("both_illegal", out_illegal, 1);
        check("both_result", out_result, 0);
        check("illegal_no_stall", in_ready, 1);
        @(posedge clk); #1;
        send(0, 0, 2'd0, 3'd0, 32'd1, 32'd1, 32'd0, 5'd10);
        @(negedge clk);
        @(posedge clk); #1;

        // Flush while both entries are full
        out_ready = 1'b0;
        send(1, 0, CTRL_ADD, 3'd0, 32'd1, 32'd1, 32'd0, 5'd11);
        send(1, 0, CTRL_ADD, 3'd0, 32'd2, 32'd2, 32'd0, 5'd12);
        @(negedge clk);
        check("pre_flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send(1, 0, CTRL_ADD, 3'd0, 32'd100, 32'd1, 32'd0, 5'd2);
        @(negedge clk);
        check("post_flush_result", out_result, 101);
        @(posedge clk); #1;

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        send(1, 0, CTRL_ADD, 3'd0, 32'd3, 32'd3, 32'd0, 5'd13);
        send(1, 0, CTRL_ADD, 3'd0, 32'd4, 32'd4, 32'd0, 5'd14);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            int k;
            k = $urandom_range(0, 9);
            uop_is_add   = (k == 0) || (k >= 2 && k < 6);
            uop_is_logic = (k == 0) || (k >= 6);
            ctrl_adder   = uop_is_add ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            ctrl_logic   = uop_is_logic ? 3'($urandom_range(1, 6)) : 3'($urandom_range(0, 7));
            op_a         = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom();
            op_b         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            imm          = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom()))) : $urandom();
            rd           = 5'($urandom_range(0, 31));
            in_valid     = ($urandom_range(0, 9) < 7);
            out_ready    = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
